pipe_mem_arbiter: RTL and testbench
===================================

Name: pipe_mem_arbiter

Overview:
- Shares one single-port instruction/data memory between the IF stage (instruction fetch) and the MEM stage (loads/stores from the EX/MEM register).
- Sequences each access over a fixed, parameterised memory latency.
- Drives the pipeline-wide `stall` that freezes IF/ID, ID/EX and EX/MEM while a data access is outstanding.
- Arbitrates with data priority plus an anti-starvation rule for fetch.

Parameters:
- LAT, 2, memory cycles per access. `mem_rdata` is valid in the last access cycle. Legal range 1..15.
- CNT_W, 4, width of the access cycle counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  32  fetch address
- if_ack  out  1  one-cycle pulse: if_instr valid
- if_instr  out  32  fetched instruction, registered
- d_rd  in  1  load request from MEM stage
- d_wr  in  1  store request from MEM stage
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_be  in  4  store byte enables
- d_ack  out  1  one-cycle pulse: data access complete
- d_rdata  out  32  load data, registered
- stall  out  1  freeze upstream pipeline registers
- mem_en  out  1  memory enable
- mem_we  out  1  memory write strobe
- mem_be  out  4  byte enables
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data

Behaviour:

States: IDLE, D_ACC, I_ACC, RESP. cnt is CNT_W bits. last_d is a 1-bit flag meaning the previous grant went to data.

IDLE:
- If (d_rd|d_wr) and not (last_d & if_req): go to D_ACC.
- Else if if_req: go to I_ACC.
- Else stay in IDLE.
- On a grant: latch addr, wdata, be, and we = d_wr (we = 0 for fetch). Set cnt = 0. Set last_d = 1 for a data grant, 0 for a fetch grant.
- d_rd and d_wr both high: treated as a write.

D_ACC / I_ACC:
- mem_en = 1 and mem_addr/mem_be/mem_wdata show the latched values for the whole state.
- mem_we = latched we only while cnt == 0, so each store issues exactly one write.
- cnt increments each cycle.
- When cnt == LAT-1: capture mem_rdata into d_rdata (D_ACC, read only) or if_instr (I_ACC), then go to RESP.
- Requests are not re-sampled during an access. Changes to the request inputs are ignored until IDLE.

RESP:
- For one cycle: d_ack = 1 if the access was data, otherwise if_ack = 1.
- Then go to IDLE.
- Stores leave d_rdata unchanged.

Outside the access states: mem_en = 0 and mem_we = 0. mem_addr/mem_be/mem_wdata hold their last values.

Latency: a request seen in IDLE in cycle t gets its ack in cycle t+LAT+1. With no contention, back-to-back accesses complete every LAT+2 cycles.

stall (combinational) = (d_rd|d_wr) & ~d_ack.
- It is low in the ack cycle, so EX/MEM advances at that edge and the completed request is not re-issued.
- Fetch back-pressure is carried only by if_ack. The IF stage holds if_addr/if_req until if_ack.

Anti-starvation: after a data grant, a pending if_req wins the next IDLE arbitration even if a data request is present. Data wins all other ties.

Reset (rst = 1 at a clock edge, including mid-access):
- state = IDLE, cnt = 0, last_d = 0.
- if_ack, d_ack, mem_en and mem_we are 0 from the cycle after the reset edge.
- if_instr, d_rdata, mem_addr, mem_wdata and mem_be are reset to 0.
- An interrupted access is abandoned with no ack.
- stall follows its equation.

LAT = 1: the access state lasts one cycle, with cnt == 0 as both the write cycle and the capture cycle.

Test Plan:
- LAT=2 load: d_rd=1, d_addr=0x10 at cycle 0, memory returns 0xDEADBEEF in cycle 2 -> mem_en=1 in cycles 1–2, d_ack=1 and d_rdata=0xDEADBEEF in cycle 3, stall=1 in cycles 0–2, stall=0 in cycle 3.
- Store: d_wr=1, d_addr=0x20, d_wdata=0x12345678, d_be=4'b0011 -> mem_we=1 only in cycle 1 with mem_be=0011, d_ack in cycle 3, d_rdata unchanged.
- Simultaneous if_req (addr 0x0) and d_rd at cycle 0 -> data is served first (d_ack in cycle 3), then fetch (if_ack in cycle 7); if_instr matches memory[0x0].
- Continuous d_rd with d_addr alternating 0x10/0x14, with if_req held high -> grants alternate D, I, D, I; if_ack occurs within 2·(LAT+2) cycles.
- rst pulsed in cycle 2 of a load -> no d_ack; cycle 3 shows IDLE, mem_en=0, d_rdata=0; a re-issued load then completes normally.
- LAT=1 load of 0xCAFEF00D -> mem_en in cycle 1 only, d_ack and rdata in cycle 2.

Source files
------------

// File: rtl/pipe_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and the MEM stage.
// Data wins ties, except that a waiting fetch always follows a data grant.
module pipe_mem_arbiter #(
  parameter int LAT   = 2,
  parameter int CNT_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_instr,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        stall,
  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, D_ACC, I_ACC, RESP} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_d_q, last_d_d;
  logic             is_d_q, is_d_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      if_instr_q, if_instr_d;
  logic [31:0]      d_rdata_q, d_rdata_d;

  logic d_req;
  logic in_acc;

  assign d_req  = d_rd | d_wr;
  assign in_acc = (state_q == D_ACC) || (state_q == I_ACC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_d_q   <= 1'b0;
      is_d_q     <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      if_instr_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_d_q   <= last_d_d;
      is_d_q     <= is_d_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      if_instr_q <= if_instr_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d_d   = last_d_q;
    is_d_d     = is_d_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    if_instr_d = if_instr_q;
    d_rdata_d  = d_rdata_q;
    case (state_q)
      IDLE: begin
        // last_d & if_req hands the slot to a fetch that waited behind data
        if (d_req && !(last_d_q && if_req)) begin
          state_d  = D_ACC;
          addr_d   = d_addr;
          wdata_d  = d_wdata;
          be_d     = d_be;
          we_d     = d_wr;
          cnt_d    = '0;
          last_d_d = 1'b1;
          is_d_d   = 1'b1;
        end else if (if_req) begin
          state_d  = I_ACC;
          addr_d   = if_addr;
          be_d     = 4'hF;
          we_d     = 1'b0;
          cnt_d    = '0;
          last_d_d = 1'b0;
          is_d_d   = 1'b0;
        end
      end
      D_ACC, I_ACC: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == LAST_CNT) begin
          if (state_q == I_ACC) begin
            if_instr_d = mem_rdata;
          end else if (!we_q) begin
            d_rdata_d = mem_rdata;
          end
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mem_en    = in_acc;
  // One write strobe per store, in the first access cycle only
  assign mem_we    = in_acc && we_q && (cnt_q == '0);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;

  assign d_ack    = (state_q == RESP) && is_d_q;
  assign if_ack   = (state_q == RESP) && !is_d_q;
  assign if_instr = if_instr_q;
  assign d_rdata  = d_rdata_q;
  assign stall    = d_req && !d_ack;

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Scoreboard bench for pipe_mem_arbiter: a LAT=2 instance under directed and
// random traffic, plus a LAT=1 instance for the single-cycle access case.
module tb_pipe_mem_arbiter;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // LAT=2 instance
  logic        if_req = 1'b0, d_rd = 1'b0, d_wr = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic [3:0]  d_be = '0;
  logic        if_ack, d_ack, stall, mem_en, mem_we;
  logic [31:0] if_instr, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  pipe_mem_arbiter #(.LAT(LAT), .CNT_W(4)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_instr(if_instr),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ack(d_ack), .d_rdata(d_rdata), .stall(stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // LAT=1 instance
  logic        l1_if_req = 1'b0, l1_d_rd = 1'b0, l1_d_wr = 1'b0;
  logic [31:0] l1_if_addr = '0, l1_d_addr = '0, l1_d_wdata = '0;
  logic [3:0]  l1_d_be = '0;
  logic        l1_if_ack, l1_d_ack, l1_stall, l1_mem_en, l1_mem_we;
  logic [31:0] l1_if_instr, l1_d_rdata, l1_mem_addr, l1_mem_wdata, l1_mem_rdata;
  logic [3:0]  l1_mem_be;

  assign l1_mem_rdata = l1_mem_en ? 32'hCAFEF00D : 32'h0;

  pipe_mem_arbiter #(.LAT(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst(rst),
    .if_req(l1_if_req), .if_addr(l1_if_addr), .if_ack(l1_if_ack), .if_instr(l1_if_instr),
    .d_rd(l1_d_rd), .d_wr(l1_d_wr), .d_addr(l1_d_addr), .d_wdata(l1_d_wdata), .d_be(l1_d_be),
    .d_ack(l1_d_ack), .d_rdata(l1_d_rdata), .stall(l1_stall),
    .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_be(l1_mem_be), .mem_addr(l1_mem_addr),
    .mem_wdata(l1_mem_wdata), .mem_rdata(l1_mem_rdata)
  );

  // Memory device: data is only driven in the last cycle of an access, junk otherwise
  logic [31:0] dev_mem  [0:127];
  logic [31:0] init_val [0:127];
  logic        fill = 1'b1;
  int          acc_cnt = 0;
  logic [31:0] junk;

  always @(posedge clk) begin
    junk    <= $urandom;
    acc_cnt <= mem_en ? acc_cnt + 1 : 0;
    if (fill) begin
      for (int i = 0; i < 128; i++) dev_mem[i] <= init_val[i];
    end else if (mem_en && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) dev_mem[mem_addr[8:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  assign mem_rdata = (mem_en && acc_cnt == LAT - 1) ? dev_mem[mem_addr[8:2]] : junk;

  // Reference model: flat word memory plus the last value a load returned
  logic [31:0] ref_mem [0:127];
  logic [31:0] last_load = '0;

  typedef struct {
    logic        st;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_v;
    int          issue;
    int          lmin;
    int          lmax;
  } txn_t;

  txn_t dq[$];
  txn_t iq[$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp_v, cycle);
    end
  endtask

  task automatic chk_rng(input string nm, input int v, input int lo, input int hi);
    n_chk++;
    if (v < lo || v > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d (cycle %0d)", nm, v, lo, hi, cycle);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_data(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input int lmin, input int lmax);
    txn_t t;
    logic got;
    t.st = wr; t.addr = addr; t.wdata = wdata; t.be = be;
    t.issue = cycle; t.lmin = lmin; t.lmax = lmax;
    if (wr) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) ref_mem[addr[8:2]][8*b +: 8] = wdata[8*b +: 8];
      t.exp_v = last_load;
    end else begin
      t.exp_v   = ref_mem[addr[8:2]];
      last_load = t.exp_v;
    end
    dq.push_back(t);
    d_rd = rd; d_wr = wr; d_addr = addr; d_wdata = wdata; d_be = be;
    got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (d_ack) begin got = 1'b1; break; end
    end
    chk("d_ack_timeout", {31'b0, got}, 32'd1);
    step();
    d_rd = 1'b0; d_wr = 1'b0;
  endtask

  task automatic do_fetch(input logic [31:0] addr, input int lmin, input int lmax);
    txn_t t;
    logic got;
    t.st = 1'b0; t.addr = addr; t.wdata = '0; t.be = '0;
    t.exp_v = ref_mem[addr[8:2]];
    t.issue = cycle; t.lmin = lmin; t.lmax = lmax;
    iq.push_back(t);
    if_addr = addr; if_req = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (if_ack) begin got = 1'b1; break; end
    end
    chk("if_ack_timeout", {31'b0, got}, 32'd1);
    step();
    if_req = 1'b0;
  endtask

  // Monitor: per-cycle stall check, access-run tracking, and ack scoreboarding
  int          run_len = 0, we_cnt = 0, we_pos = 0;
  logic        prev_en = 1'b0;
  logic [31:0] we_addr = '0, we_data = '0;
  logic [3:0]  we_be = '0;

  initial begin
    txn_t t;
    forever begin
      @(negedge clk);
      chk("stall", {31'b0, stall}, {31'b0, (d_rd | d_wr) & ~d_ack});
      if (mem_en) begin
        if (!prev_en) begin
          run_len = 1; we_cnt = 0; we_pos = 0;
        end else begin
          run_len++;
        end
        if (mem_we) begin
          we_cnt++; we_pos = run_len;
          we_addr = mem_addr; we_data = mem_wdata; we_be = mem_be;
        end
      end
      prev_en = mem_en;
      if (d_ack) begin
        if (dq.size() == 0) begin
          chk("d_ack_spurious", {31'b0, d_ack}, 32'd0);
        end else begin
          t = dq.pop_front();
          chk_rng("d_latency", cycle - t.issue, t.lmin, t.lmax);
          chk("d_rdata", d_rdata, t.exp_v);
          chk("d_mem_addr", mem_addr, t.addr);
          chk("d_run_len", run_len, LAT);
          chk("d_we_count", we_cnt, t.st ? 32'd1 : 32'd0);
          if (t.st) begin
            chk("d_we_pos", we_pos, 32'd1);
            chk("d_we_addr", we_addr, t.addr);
            chk("d_we_data", we_data, t.wdata);
            chk("d_we_be", {28'b0, we_be}, {28'b0, t.be});
          end
          $display("data %s addr=0x%08h rdata=0x%08h lat=%0d", t.st ? "ST" : "LD",
                   t.addr, d_rdata, cycle - t.issue);
        end
      end
      if (if_ack) begin
        if (iq.size() == 0) begin
          chk("if_ack_spurious", {31'b0, if_ack}, 32'd0);
        end else begin
          t = iq.pop_front();
          chk_rng("if_latency", cycle - t.issue, t.lmin, t.lmax);
          chk("if_instr", if_instr, t.exp_v);
          chk("if_mem_addr", mem_addr, t.addr);
          chk("if_run_len", run_len, LAT);
          chk("if_we_count", we_cnt, 32'd0);
          $display("fetch addr=0x%08h instr=0x%08h lat=%0d", t.addr, if_instr, cycle - t.issue);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 128; i++) begin
      init_val[i] = $urandom;
    end
    init_val[32'h110 >> 2] = 32'hDEADBEEF;
    for (int i = 0; i < 128; i++) ref_mem[i] = init_val[i];

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; fill = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_if_ack", {31'b0, if_ack}, 32'd0);
    chk("rst_d_ack", {31'b0, d_ack}, 32'd0);
    chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_be", {28'b0, mem_be}, 32'd0);
    chk("rst_l1_d_rdata", l1_d_rdata, 32'd0);
    step();

    // Single-cycle access instance
    l1_d_rd = 1'b1; l1_d_addr = 32'h40;
    @(negedge clk);
    chk("l1_c0_mem_en", {31'b0, l1_mem_en}, 32'd0);
    chk("l1_c0_stall", {31'b0, l1_stall}, 32'd1);
    step();
    @(negedge clk);
    chk("l1_c1_mem_en", {31'b0, l1_mem_en}, 32'd1);
    chk("l1_c1_d_ack", {31'b0, l1_d_ack}, 32'd0);
    step();
    @(negedge clk);
    chk("l1_c2_mem_en", {31'b0, l1_mem_en}, 32'd0);
    chk("l1_c2_d_ack", {31'b0, l1_d_ack}, 32'd1);
    chk("l1_c2_d_rdata", l1_d_rdata, 32'hCAFEF00D);
    chk("l1_c2_stall", {31'b0, l1_stall}, 32'd0);
    $display("lat1 load addr=0x%08h rdata=0x%08h", l1_d_addr, l1_d_rdata);
    step();
    l1_d_rd = 1'b0;

    // Uncontended accesses complete LAT+1 cycles after the request
    do_fetch(32'h0, LAT + 1, LAT + 1);
    do_data(1'b1, 1'b0, 32'h110, 32'h0, 4'h0, LAT + 1, LAT + 1);
    do_data(1'b0, 1'b1, 32'h120, 32'h12345678, 4'b0011, LAT + 1, LAT + 1);
    do_data(1'b1, 1'b0, 32'h120, 32'h0, 4'h0, LAT + 1, LAT + 1);

    // Reset in the capture cycle of a load: abandoned, no ack
    d_rd = 1'b1; d_addr = 32'h114;
    step();
    @(negedge clk);
    chk("abort_c1_mem_en", {31'b0, mem_en}, 32'd1);
    step();
    rst = 1'b1; d_rd = 1'b0;
    step();
    rst = 1'b0;
    last_load = '0;
    @(negedge clk);
    chk("abort_mem_en", {31'b0, mem_en}, 32'd0);
    chk("abort_d_ack", {31'b0, d_ack}, 32'd0);
    chk("abort_d_rdata", d_rdata, 32'd0);
    chk("abort_mem_addr", mem_addr, 32'd0);
    step();

    // Simultaneous requests: data first, fetch follows one access later
    fork
      do_data(1'b1, 1'b0, 32'h110, 32'h0, 4'h0, LAT + 1, LAT + 1);
      do_fetch(32'h4, 2 * LAT + 3, 2 * LAT + 3);
    join

    // Random contention; neither side may wait more than two access slots
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          int gap, kind;
          logic [31:0] a;
          gap  = $urandom_range(0, 2);
          kind = $urandom_range(0, 3);
          a    = 32'h100 | ($urandom_range(0, 7) << 2);
          repeat (gap) step();
          case (kind)
            0, 1:    do_data(1'b1, 1'b0, a, 32'h0, 4'h0, LAT + 1, 2 * LAT + 4);
            2:       do_data(1'b0, 1'b1, a, $urandom, 4'($urandom_range(1, 15)), LAT + 1, 2 * LAT + 4);
            default: do_data(1'b1, 1'b1, a, $urandom, 4'($urandom_range(1, 15)), LAT + 1, 2 * LAT + 4);
          endcase
        end
      end
      begin
        for (int n = 0; n < 40; n++) begin
          int gap;
          gap = $urandom_range(0, 2);
          repeat (gap) step();
          do_fetch($urandom_range(0, 63) << 2, LAT + 1, 2 * LAT + 4);
        end
      end
    join

    repeat (5) step();
    chk("dq_drained", dq.size(), 32'd0);
    chk("iq_drained", iq.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
